// File: rtl/fir_out.sv
// FIR result output stage: shift/saturate, show-ahead FIFO, frame counter and status FSM.
// Optional FIR_OUT_ROUND_EN adds round-half-up ahead of the shift.
module fir_out #(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [3:0]                 shift,
  input  logic [15:0]                out_len,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data_i,
  input  logic [IN_W-1:0]            in_data_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data_i,
  output logic [OUT_W-1:0]           out_data_q,
  output logic                       out_last,
  output logic                       tx_busy,
  output logic                       tx_done,
  output logic                       tx_overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = IN_W + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state, state_nxt;
  logic               s1_valid;
  logic [OUT_W-1:0]   s1_i, s1_q;
  logic [OUT_W-1:0]   mem_i [DEPTH];
  logic [OUT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      count;
  logic [15:0]        beat_cnt;
  logic               ovf;
  logic               full, pop, push_ok, frame_end;

  // One extra bit keeps the rounding add from overflowing.
  function automatic logic signed [EW-1:0] scale_fn(input logic [IN_W-1:0] x,
                                                    input logic [3:0] sh);
    logic signed [EW-1:0] ext;
    ext = {x[IN_W-1], x};
`ifdef FIR_OUT_ROUND_EN
    if (sh != 4'd0) ext = ext + (EW'(1) << (sh - 4'd1));
`endif
    return ext >>> sh;
  endfunction

  function automatic logic [OUT_W-1:0] sat_fn(input logic signed [EW-1:0] v);
    if (v > MAX_V) return MAX_V[OUT_W-1:0];
    if (v < MIN_V) return MIN_V[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  assign out_valid = (count != LW'(0));
  assign full      = (count == LW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push_ok   = s1_valid & (~full | pop);
  assign out_last  = out_valid & (out_len != 16'd0) & (beat_cnt == out_len - 16'd1);
  assign frame_end = pop & out_last;

  assign out_data_i  = out_valid ? mem_i[rd_ptr] : '0;
  assign out_data_q  = out_valid ? mem_q[rd_ptr] : '0;
  assign level       = count;
  assign tx_overflow = ovf;
  assign tx_done     = (state == DONE);
  assign tx_busy     = (state == ACTIVE) | out_valid | s1_valid;

  // Stage 1: scale and saturate each component.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_i <= sat_fn(scale_fn(in_data_i, shift));
        s1_q <= sat_fn(scale_fn(in_data_q, shift));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_i[wr_ptr] <= s1_i;
      mem_q[wr_ptr] <= s1_q;
    end
  end

  // FIFO pointers, occupancy, overflow flag and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      beat_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (s1_valid && full && !pop) ovf <= 1'b1;
      if (pop) beat_cnt <= out_last ? 16'd0 : beat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A frame ending in the DONE cycle itself re-enters DONE for that frame.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (push_ok) state_nxt = ACTIVE;
        ACTIVE:  if (frame_end) state_nxt = DONE;
        DONE: begin
          if (frame_end)                state_nxt = DONE;
          else if (out_valid | push_ok) state_nxt = ACTIVE;
          else                          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
